// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_pkg
// Brief    : Shared fetch-state encoding, instruction field positions and PC step.
// Revision : 1.0
// ============================================================================
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BUF  = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    localparam int unsigned PC_INC = 4;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg
// Brief    : Program counter with synchronous reset, load and increment-by-4.
// Revision : 1.0
// ============================================================================
module pc_reg
    import instr_fetch_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] pc_o
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Load wins over increment; the add wraps naturally at 2^WIDTH.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + WIDTH'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Single-outstanding instruction fetch with IF/ID register and skid buffer.
// Revision : 1.0
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_valid,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    output logic [5:0]       opcode,
    output logic [5:0]       functi
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic             buf_valid_q, buf_valid_d;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] redirect_tgt;
    logic             pc_load;
    logic             pc_inc;
    logic             out_free;

    assign redirect_tgt = {redirect_pc[WIDTH-1:2], 2'b00};
    assign out_free     = !valid_q || !stall;

    pc_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .load_val_i (redirect_tgt),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q && stall;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;

        if (redirect) begin
            pc_load     = 1'b1;
            valid_d     = 1'b0;
            buf_valid_d = 1'b0;
            // A request still in flight must be drained in DROP; a response
            // landing this very cycle leaves nothing outstanding.
            if ((state_q == WAIT || state_q == DROP) && !imem_valid) begin
                state_d = DROP;
            end else begin
                state_d = WAIT;
            end
        end else begin
            case (state_q)
                IDLE: state_d = WAIT;
                WAIT: begin
                    if (imem_valid) begin
                        pc_inc = 1'b1;
                        if (out_free) begin
                            instr_d    = imem_rdata;
                            instr_pc_d = pc;
                            valid_d    = 1'b1;
                        end else begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc;
                            buf_valid_d = 1'b1;
                            state_d     = BUF;
                        end
                    end
                end
                BUF: begin
                    if (buf_valid_q && !stall) begin
                        instr_d     = buf_instr_q;
                        instr_pc_d  = buf_pc_q;
                        valid_d     = 1'b1;
                        buf_valid_d = 1'b0;
                        state_d     = WAIT;
                    end
                end
                DROP: begin
                    if (imem_valid) begin
                        state_d = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            valid_q     <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign imem_req    = (state_q == WAIT);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign functi      = instr_q[FUNCT_MSB:FUNCT_LSB];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed vector bench for instr_fetch, plus a wrap/redirect-from-IDLE sequence.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Primary DUT (RESET_PC = 0)
    logic        reset = 1'b1, stall = 1'b0, redirect = 1'b0, imem_valid = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic [31:0] imem_addr, instr, instr_pc;
    logic        imem_req, instr_valid;
    logic [5:0]  opcode, functi;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .functi      (functi)
    );

    // Second DUT exercising PC wrap from the top of the address space
    logic        reset2 = 1'b1, redirect2 = 1'b0, imem_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = '0, imem_rdata2 = '0;
    logic [31:0] imem_addr2, instr2, instr_pc2;
    logic        imem_req2, instr_valid2;
    logic [5:0]  opcode2, functi2;

    instr_fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk         (clk),
        .reset       (reset2),
        .imem_addr   (imem_addr2),
        .imem_req    (imem_req2),
        .imem_rdata  (imem_rdata2),
        .imem_valid  (imem_valid2),
        .stall       (1'b0),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .instr_valid (instr_valid2),
        .opcode      (opcode2),
        .functi      (functi2)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        iv;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eiv;
        logic [31:0] eipc;
        logic [31:0] einstr;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic v(input logic rst, input logic stl, input logic rd, input logic [31:0] rpc,
                     input logic iv, input logic [31:0] rdata, input logic ereq,
                     input logic [31:0] eaddr, input logic eiv, input logic [31:0] eipc,
                     input logic [31:0] einstr);
        vecs.push_back('{rst, stl, rd, rpc, iv, rdata, ereq, eaddr, eiv, eipc, einstr});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //  rst stl rd rpc        iv rdata          req addr         iv ipc          instr
        v(1, 0, 0, 32'h0,   0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0);
        v(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h0,   0, 32'h0,   32'h0);
        v(0, 0, 0, 32'h0,   1, 32'h0000_0020, 1, 32'h4,   1, 32'h0,   32'h0000_0020);
        v(0, 0, 0, 32'h0,   1, 32'h8C00_0000, 1, 32'h8,   1, 32'h4,   32'h8C00_0000);
        v(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h8,   0, 32'h4,   32'h8C00_0000);
        v(0, 0, 0, 32'h0,   1, 32'h1111_1111, 1, 32'hC,   1, 32'h8,   32'h1111_1111);
        v(0, 1, 0, 32'h0,   1, 32'h2222_2222, 0, 32'h10,  1, 32'h8,   32'h1111_1111);
        v(0, 1, 0, 32'h0,   0, 32'h0,        0, 32'h10,  1, 32'h8,   32'h1111_1111);
        v(0, 1, 0, 32'h0,   1, 32'h0000_DEAD, 0, 32'h10,  1, 32'h8,   32'h1111_1111);
        v(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h10,  1, 32'hC,   32'h2222_2222);
        v(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h10,  0, 32'hC,   32'h2222_2222);
        v(0, 0, 1, 32'h103, 0, 32'h0,        0, 32'h100, 0, 32'hC,   32'h2222_2222);
        v(0, 0, 0, 32'h0,   0, 32'h0,        0, 32'h100, 0, 32'hC,   32'h2222_2222);
        v(0, 0, 0, 32'h0,   1, 32'hBADB_AD00, 1, 32'h100, 0, 32'hC,   32'h2222_2222);
        v(0, 0, 0, 32'h0,   1, 32'h0000_0021, 1, 32'h104, 1, 32'h100, 32'h0000_0021);
        v(0, 1, 1, 32'h200, 1, 32'h3333_3333, 1, 32'h200, 0, 32'h100, 32'h0000_0021);
        v(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h200, 0, 32'h100, 32'h0000_0021);
        v(0, 0, 1, 32'h300, 0, 32'h0,        0, 32'h300, 0, 32'h100, 32'h0000_0021);
        v(0, 0, 1, 32'h407, 0, 32'h0,        0, 32'h404, 0, 32'h100, 32'h0000_0021);
        v(0, 0, 0, 32'h0,   1, 32'h9999_9999, 1, 32'h404, 0, 32'h100, 32'h0000_0021);
        v(0, 0, 0, 32'h0,   1, 32'h4444_4444, 1, 32'h408, 1, 32'h404, 32'h4444_4444);
        v(0, 1, 0, 32'h0,   1, 32'h5555_5555, 0, 32'h40C, 1, 32'h404, 32'h4444_4444);
        v(0, 1, 1, 32'h500, 0, 32'h0,        1, 32'h500, 0, 32'h404, 32'h4444_4444);
        v(0, 0, 0, 32'h0,   1, 32'h6666_6666, 1, 32'h504, 1, 32'h500, 32'h6666_6666);
        v(1, 0, 0, 32'h0,   1, 32'h7777_7777, 0, 32'h0,   0, 32'h0,   32'h0);
        v(0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h0,   0, 32'h0,   32'h0);
        v(0, 0, 0, 32'h0,   1, 32'h8888_8888, 1, 32'h4,   1, 32'h0,   32'h8888_8888);
        v(0, 1, 0, 32'h0,   0, 32'h0,        1, 32'h4,   1, 32'h0,   32'h8888_8888);

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            imem_valid  = vecs[i].iv;
            imem_rdata  = vecs[i].rdata;
            step();
            chk("imem_req",    i, {31'b0, imem_req},    {31'b0, vecs[i].ereq});
            chk("imem_addr",   i, imem_addr,            vecs[i].eaddr);
            chk("instr_valid", i, {31'b0, instr_valid}, {31'b0, vecs[i].eiv});
            chk("instr_pc",    i, instr_pc,             vecs[i].eipc);
            chk("instr",       i, instr,                vecs[i].einstr);
            chk("opcode",      i, {26'b0, opcode},      {26'b0, vecs[i].einstr[31:26]});
            chk("functi",      i, {26'b0, functi},      {26'b0, vecs[i].einstr[5:0]});
        end

        // Wrap DUT: reset value, redirect straight out of IDLE, then wrap past 0xFFFF_FFFC.
        reset2 = 1'b1;
        step();
        chk("w_rst_addr", 0, imem_addr2, 32'hFFFF_FFFC);
        chk("w_rst_req",  0, {31'b0, imem_req2}, 32'h0);
        reset2 = 1'b0; redirect2 = 1'b1; redirect_pc2 = 32'h0000_1003;
        step();
        chk("w_idle_redir_addr", 1, imem_addr2, 32'h0000_1000);
        chk("w_idle_redir_req",  1, {31'b0, imem_req2}, 32'h1);
        redirect2 = 1'b0; imem_valid2 = 1'b1; imem_rdata2 = 32'hABCD_0001;
        step();
        chk("w_instr_pc", 2, instr_pc2, 32'h0000_1000);
        chk("w_addr",     2, imem_addr2, 32'h0000_1004);
        imem_valid2 = 1'b0; reset2 = 1'b1;
        step();
        chk("w_rst_valid", 3, {31'b0, instr_valid2}, 32'h0);
        reset2 = 1'b0;
        step();
        chk("w_first_addr", 4, imem_addr2, 32'hFFFF_FFFC);
        imem_valid2 = 1'b1; imem_rdata2 = 32'h1234_5678;
        step();
        chk("w_wrap_addr",  5, imem_addr2, 32'h0000_0000);
        chk("w_wrap_ipc",   5, instr_pc2, 32'hFFFF_FFFC);
        chk("w_wrap_valid", 5, {31'b0, instr_valid2}, 32'h1);
        chk("w_wrap_instr", 5, instr2, 32'h1234_5678);
        imem_valid2 = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, datapath/address width; RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1, synchronous, active-high reset.
REQ-004 Port imem_addr, output, WIDTH, word address of the outstanding fetch.
REQ-005 Port imem_req, output, 1, fetch request; SHALL be held with a stable imem_addr until imem_valid.
REQ-006 Port imem_rdata, input, WIDTH, instruction word; qualified by imem_valid.
REQ-007 Port imem_valid, input, 1, one-cycle response pulse; response latency >=1 cycle, at most one request outstanding.
REQ-008 Port stall, input, 1, decode stage cannot accept; hold the current output.
REQ-009 Port redirect, input, 1, taken branch/jump/jr from the execute stage.
REQ-010 Port redirect_pc, input, WIDTH, redirect target; bits [1:0] SHALL be ignored (forced 00).
REQ-011 Port instr, output, WIDTH, registered IF/ID instruction.
REQ-012 Port instr_pc, output, WIDTH, address of instr.
REQ-013 Port instr_valid, output, 1, instr/instr_pc/opcode/functi are meaningful.
REQ-014 Port opcode, output, 6, instr[31:26], registered with instr; feeds the main decoder.
REQ-015 Port functi, output, 6, instr[5:0], registered with instr; feeds the main decoder.

Function
REQ-016 States SHALL be IDLE, WAIT, BUF and DROP.
REQ-017 IDLE: imem_req=0; next cycle go to WAIT with imem_addr=pc.
REQ-018 WAIT: imem_req=1, imem_addr=pc. On imem_valid with the output free, instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, and stay in WAIT. The output is free when instr_valid=0 or stall=0.
REQ-019 WAIT: on imem_valid with instr_valid=1 and stall=1, capture the word and its pc into a one-entry buffer, pc<=pc+4, and go to BUF.
REQ-020 BUF: imem_req=0; when stall=0, move the buffer into the output registers and go to WAIT.
REQ-021 DROP: imem_req=0; on imem_valid, discard imem_rdata and go to WAIT.
REQ-022 If instr_valid=1, stall=0 and no new word is loaded, instr_valid SHALL drop to 0 next cycle.
REQ-023 While stall=1, instr, instr_pc, opcode, functi and instr_valid SHALL hold their values.
REQ-024 redirect SHALL have priority over stall and imem_valid. Next cycle: pc<={redirect_pc[WIDTH-1:2],2'b00}, instr_valid=0, buffer invalidated.
REQ-025 Redirect state transitions SHALL be:
- redirect in WAIT without imem_valid -> DROP;
- redirect in WAIT with imem_valid in the same cycle -> word discarded, go to WAIT;
- redirect in BUF or IDLE -> WAIT;
- redirect in DROP -> stay in DROP with pc updated.
REQ-026 pc+4 SHALL wrap modulo 2^WIDTH (FFFF_FFFC -> 0000_0000).
REQ-027 Fetch-to-output latency SHALL be exactly one cycle after imem_valid when the output is free.
REQ-028 imem_valid outside WAIT/DROP SHALL be ignored.

Reset
REQ-029 During reset, pc SHALL be RESET_PC and the state SHALL be IDLE.
REQ-030 During reset, these outputs SHALL be 0: imem_req, instr_valid, instr, instr_pc, opcode, functi.
REQ-031 During reset, imem_addr SHALL be RESET_PC and the buffer SHALL be invalid.
REQ-032 Reset asserted mid-fetch SHALL abandon the request with no DROP. The memory is reset by the same signal.

Structure
REQ-033 A shared package SHALL hold the fetch state enum, the opcode/functi field bit positions and the PC increment constant (4).
REQ-034 One sub-module, pc_reg, SHALL be instantiated: a WIDTH-bit register with synchronous reset, load and increment-by-4.

Verification
REQ-035 Reset release, memory with 1-cycle latency returning 0x00000020 then 0x8C000000 -> instr_valid on consecutive words, instr_pc 0x0 then 0x4, opcode 000000/functi 100000 then opcode 100011.
REQ-036 stall=1 for 3 cycles while a response arrives -> output held, word held in BUF, imem_req=0; on stall=0 the buffered word appears with instr_pc 0x8.
REQ-037 redirect with redirect_pc=0x0000_0103 while a 3-cycle-latency fetch is pending -> DROP, late word discarded, next imem_addr=0x0000_0100, instr_valid=0 meanwhile.
REQ-038 redirect in the same cycle as imem_valid and stall -> word discarded, instr_valid=0 next cycle, imem_addr=target.
REQ-039 RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000.
REQ-040 reset asserted mid-WAIT -> all outputs 0 next cycle, fetch restarts at RESET_PC, no stale word delivered.
